// File: rtl/dm_responder_pkg.sv
// Shared CPU package: data-memory FSM states, access widths and alignment rule.
// Also imported by ex_mem_decoder so both sides agree on byte_width codes.
package dm_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] BW_WORD = 2'b00;
    localparam logic [1:0] BW_HALF = 2'b01;
    localparam logic [1:0] BW_BYTE = 2'b10;
    localparam logic [1:0] BW_RSVD = 2'b11;

    // Reserved width counts as misaligned so callers need one check only.
    function automatic logic bad_align(
        input logic [1:0] bw,
        input logic [1:0] lane
    );
        case (bw)
            BW_WORD: return lane != 2'b00;
            BW_HALF: return lane[0];
            BW_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Little-endian lane extract/insert with load sign/zero extension.
// Purely combinational; merges store data into the old word.
module dm_lane_align
    import dm_responder_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  byte_width,
    input  logic        sign_ext,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [15:0] half;
    logic [7:0]  bsel;

    assign half = lane[1] ? mem_word[31:16] : mem_word[15:0];
    assign bsel = mem_word[{lane, 3'b000} +: 8];

    always_comb begin
        load_data  = mem_word;
        store_word = wdata;
        case (byte_width)
            BW_HALF: begin
                load_data  = {{16{sign_ext & half[15]}}, half};
                store_word = lane[1] ? {wdata[15:0], mem_word[15:0]}
                                     : {mem_word[31:16], wdata[15:0]};
            end
            BW_BYTE: begin
                load_data  = {{24{sign_ext & bsel[7]}}, bsel};
                store_word = mem_word;
                store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: wait-stated single-port word storage for the CPU
// data port with lane alignment, extension and error reporting.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  byte_width,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        error
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  bw_q;
    logic        sx_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        idle;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [1:0]  cur_bw;
    logic        cur_sx;
    logic        bad;
    logic        access;
    logic [AW-1:0] idx;
    logic [31:0] load_data;
    logic [31:0] store_word;

    // With zero wait states the access happens on the capture edge itself,
    // so operands come straight from the port while idle.
    assign idle      = state == ST_IDLE;
    assign cur_we    = idle ? we : we_q;
    assign cur_addr  = idle ? addr : addr_q;
    assign cur_wdata = idle ? wdata : wdata_q;
    assign cur_bw    = idle ? byte_width : bw_q;
    assign cur_sx    = idle ? sign_ext : sx_q;

    assign bad = bad_align(cur_bw, cur_addr[1:0])
              || (cur_addr[31:2] >= DEPTH_L);

    assign access = (idle && req && (WAIT_CYCLES == 0))
                 || (state == ST_WAIT && cnt == 4'd1);

    assign idx = cur_addr[AW+1:2];

    dm_lane_align u_align (
        .mem_word   (mem[idx]),
        .wdata      (cur_wdata),
        .lane       (cur_addr[1:0]),
        .byte_width (cur_bw),
        .sign_ext   (cur_sx),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (!reset && access && cur_we && !bad) begin
            mem[idx] <= store_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            ready <= 1'b0;
            error <= 1'b0;
            rdata <= 32'd0;
        end else begin
            ready <= access;
            if (access) begin
                error <= bad;
                rdata <= (bad || cur_we) ? 32'd0 : load_data;
            end
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        bw_q    <= byte_width;
                        sx_q    <= sign_ext;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder with a byte-level memory model and a
// per-cycle compare process; a second zero-wait instance covers back-to-back.
module tb_dm_responder;

    localparam int DW = 64;
    localparam int W  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, sign_ext;
    logic [31:0] addr, wdata;
    logic [1:0]  byte_width;
    logic [31:0] rdata;
    logic        ready, error;

    logic        req_z, we_z, sx_z;
    logic [31:0] addr_z, wdata_z;
    logic [1:0]  bw_z;
    logic [31:0] rdata_z;
    logic        ready_z, error_z;

    dm_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .byte_width(byte_width), .sign_ext(sign_ext),
        .rdata(rdata), .ready(ready), .error(error)
    );

    dm_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset), .req(req_z), .we(we_z), .addr(addr_z),
        .wdata(wdata_z), .byte_width(bw_z), .sign_ext(sx_z),
        .rdata(rdata_z), .ready(ready_z), .error(error_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        er;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [7:0]  mb [DW*4];
    exp_t        q[$];
    logic [31:0] last_rd = 32'd0;
    logic        last_er = 1'b0;
    logic        rs;
    logic        exp_rdy;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Memory viewed as a flat byte array; widths are just byte counts.
    function automatic exp_t model(input logic w, input logic [31:0] a,
                                   input logic [31:0] d, input logic [1:0] bw,
                                   input logic sx);
        exp_t e;
        int n;
        logic [31:0] v;
        e.due = 0;
        e.rd  = 32'd0;
        e.er  = 1'b0;
        n = (bw == 2'b00) ? 4 : (bw == 2'b01) ? 2 : (bw == 2'b10) ? 1 : 0;
        if (n == 0) begin
            e.er = 1'b1;
            return e;
        end
        if ((a % n) != 0 || a >= DW*4) begin
            e.er = 1'b1;
            return e;
        end
        if (w) begin
            for (int i = 0; i < n; i++) mb[a+i] = d[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a+i];
            if (sx && n < 4 && v[8*n-1])
                for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
            e.rd = v;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        rs = reset;
        #2;
        if (rs) begin
            q.delete();
            last_rd = 32'd0;
            last_er = 1'b0;
            chk("reset_ready", 32'(ready), 32'd0);
        end else begin
            exp_rdy = (q.size() > 0) && (q[0].due == cyc);
            chk("ready", 32'(ready), 32'(exp_rdy));
            if (exp_rdy) begin
                last_rd = q[0].rd;
                last_er = q[0].er;
                void'(q.pop_front());
            end
        end
        chk("rdata", rdata, last_rd);
        chk("error", 32'(error), 32'(last_er));
    end

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] bw,
                        input logic sx, input bit pin,
                        input logic [31:0] pin_rd, input logic pin_er);
        exp_t e;
        int n;
        @(negedge clk);
        req = 1'b1;
        we = w;
        addr = a;
        wdata = d;
        byte_width = bw;
        sign_ext = sx;
        e = model(w, a, d, bw, sx);
        e.due = cyc + 1 + W;
        q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 40);
        req = 1'b0;
        chk("latency", 32'(n), 32'(W + 1));
        if (pin) begin
            chk("pin_rdata", rdata, pin_rd);
            chk("pin_error", 32'(error), 32'(pin_er));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        logic [5:0] pat;
        reset = 1'b1;
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        byte_width = 2'b00; sign_ext = 1'b0;
        req_z = 1'b0; we_z = 1'b0; addr_z = 32'd0; wdata_z = 32'd0;
        bw_z = 2'b00; sx_z = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_lit_rdata", rdata, 32'd0);
        chk("reset_lit_ready", 32'(ready), 32'd0);
        reset = 1'b0;

        xfer(1, 32'h10, 32'hDEADBEEF, 2'b00, 0, 1, 32'h0, 0);
        xfer(0, 32'h10, 32'h0, 2'b00, 0, 1, 32'hDEADBEEF, 0);
        xfer(1, 32'h13, 32'h00000080, 2'b10, 0, 1, 32'h0, 0);
        xfer(0, 32'h13, 32'h0, 2'b10, 1, 1, 32'hFFFFFF80, 0);
        xfer(0, 32'h13, 32'h0, 2'b10, 0, 1, 32'h00000080, 0);
        xfer(0, 32'h12, 32'h0, 2'b01, 0, 1, 32'h000080AD, 0);
        xfer(0, 32'h12, 32'h0, 2'b01, 1, 0, 32'h0, 0);
        xfer(0, 32'h10, 32'h0, 2'b10, 1, 0, 32'h0, 0);
        xfer(0, 32'h11, 32'h0, 2'b10, 0, 0, 32'h0, 0);
        xfer(1, 32'h14, 32'h01020304, 2'b00, 0, 0, 32'h0, 0);
        xfer(1, 32'h16, 32'h1234BEEF, 2'b01, 0, 0, 32'h0, 0);
        xfer(0, 32'h14, 32'h0, 2'b00, 1, 1, 32'hBEEF0304, 0);
        xfer(0, 32'h11, 32'h0, 2'b01, 0, 1, 32'h0, 1);
        xfer(1, 32'h20, 32'h11223344, 2'b00, 0, 0, 32'h0, 0);
        xfer(1, 32'h22, 32'hFFFFFFFF, 2'b00, 0, 1, 32'h0, 1);
        xfer(0, 32'h20, 32'h0, 2'b00, 0, 1, 32'h11223344, 0);
        xfer(0, 32'(DW*4), 32'h0, 2'b00, 0, 1, 32'h0, 1);
        xfer(1, 32'(DW*4 - 4), 32'hA5A55A5A, 2'b00, 0, 0, 32'h0, 0);
        xfer(0, 32'(DW*4 - 4), 32'h0, 2'b00, 0, 1, 32'hA5A55A5A, 0);
        xfer(0, 32'h10, 32'h0, 2'b11, 0, 1, 32'h0, 1);

        // Store interrupted by reset while waiting must leave no trace.
        xfer(1, 32'h40, 32'hCAFEF00D, 2'b00, 0, 0, 32'h0, 0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h12345678;
        byte_width = 2'b00; sign_ext = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        xfer(0, 32'h40, 32'h0, 2'b00, 0, 1, 32'hCAFEF00D, 0);

        // Zero-wait instance with req held: ready on alternate cycles.
        @(negedge clk);
        req_z = 1'b1; we_z = 1'b1; addr_z = 32'h4;
        wdata_z = 32'h5A5A5A5A; bw_z = 2'b00; sx_z = 1'b0;
        pat = 6'b010101;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(ready_z), 32'(pat[i]));
            if (pat[i]) begin
                chk("b2b_error", 32'(error_z), 32'd0);
                chk("b2b_rdata", rdata_z, 32'd0);
            end
        end
        we_z = 1'b0;
        @(negedge clk);
        chk("z_load_ready", 32'(ready_z), 32'd1);
        chk("z_load_rdata", rdata_z, 32'h5A5A5A5A);
        req_z = 1'b0;
        @(negedge clk);
        chk("z_idle_ready", 32'(ready_z), 32'd0);
        chk("z_hold_rdata", rdata_z, 32'h5A5A5A5A);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
